// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: next PC, PC write enable, stalled-redirect hold, illegal-target halt.
// Latency: pc_next/pc_en/fetch_valid combinational in the same cycle; addr_fault/fetch_cnt registered.
// Backpressure: stall freezes the PC; a redirect seen under stall is held until the first unstalled cycle.
module f_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic [31:0] pc_next,
    output logic        pc_en,
    output logic        fetch_valid,
    output logic        addr_fault,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_WORDS) - 32'd4;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state;
    logic [31:0] pend_target;
    logic        want_en;
    logic        legal;
    logic        fault;

    always_comb begin
        pc_next     = pc + 32'd4;
        want_en     = 1'b0;
        fetch_valid = 1'b0;
        if (!reset) begin
            pc_next = PC_RESET;
        end else begin
            case (state)
                S_RUN: begin
                    fetch_valid = 1'b1;
                    want_en     = !stall;
                    if (redir_valid)
                        pc_next = redir_target;
                end
                S_PEND: begin
                    // The branch is still held in D, so any redir_valid now is the same redirect.
                    fetch_valid = 1'b1;
                    want_en     = !stall;
                    pc_next     = pend_target;
                end
                default: begin
                    pc_next = pc;
                end
            endcase
        end
    end

    assign legal = (pc_next[1:0] == 2'b00) && (pc_next >= PC_RESET) && (pc_next <= PC_LAST);
    assign fault = want_en && !legal;
    assign pc_en = want_en && legal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_RUN;
            pend_target <= PC_RESET;
            addr_fault  <= 1'b0;
            fetch_cnt   <= 32'd0;
        end else begin
            if (pc_en)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (fault) begin
                state      <= S_HALT;
                addr_fault <= 1'b1;
            end else begin
                case (state)
                    S_RUN: begin
                        if (stall && redir_valid) begin
                            pend_target <= redir_target;
                            state       <= S_PEND;
                        end
                    end
                    S_PEND: begin
                        if (!stall)
                            state <= S_RUN;
                    end
                    default: begin
                        state <= S_HALT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Bench for f_fetch_ctrl: directed scenarios plus random traffic, scored against a queue-based model.
module tb_f_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        fetch_valid;
    logic        addr_fault;
    logic [31:0] fetch_cnt;

    always #5 clk = ~clk;

    f_fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .fetch_valid  (fetch_valid),
        .addr_fault   (addr_fault),
        .fetch_cnt    (fetch_cnt)
    );

    typedef struct {
        logic [31:0] pc_next;
        bit          chk_next;
        bit          pc_en;
        bit          fetch_valid;
        bit          chk_reg;
        bit          addr_fault;
        logic [31:0] fetch_cnt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    // Reference model: the bench also plays the PC register, fed only from the model.
    logic [31:0] m_pc    = 32'h0000_3000;
    logic [31:0] m_cnt   = 32'd0;
    bit          m_halt  = 1'b0;
    bit          m_fault = 1'b0;
    bit          m_known = 1'b0;
    logic [31:0] m_pend[$];

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h3000 + 32'd4 * 32'd4096 - 32'd4);
    endfunction

    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rt);
        exp_t        e;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        reset        = r;
        stall        = s;
        redir_valid  = rv;
        redir_target = rt;
        pc           = m_pc;
        e.chk_reg    = m_known;
        e.addr_fault = m_fault;
        e.fetch_cnt  = m_cnt;
        e.chk_next   = 1'b1;
        e.cyc        = cyc;
        cyc++;
        if (!r) begin
            e.pc_next = 32'h3000; e.pc_en = 1'b0; e.fetch_valid = 1'b0;
            sb.push_back(e);
            m_halt = 1'b0; m_fault = 1'b0; m_cnt = 32'd0; m_known = 1'b1;
            m_pend.delete();
            m_pc = 32'h3000;
            return;
        end
        if (m_halt) begin
            e.pc_next = m_pc; e.pc_en = 1'b0; e.fetch_valid = 1'b0;
            sb.push_back(e);
            return;
        end
        e.fetch_valid = 1'b1;
        if (m_pend.size() != 0)
            tgt = m_pend[0];
        else if (rv)
            tgt = rt;
        else
            tgt = m_pc + 32'd4;
        if (s && rv && m_pend.size() == 0) begin
            e.chk_next = 1'b0;
            m_pend.push_back(rt);
        end
        e.pc_next = tgt;
        e.pc_en   = !s && legal(tgt);
        sb.push_back(e);
        if (!s) begin
            if (legal(tgt)) begin
                m_pc = tgt;
                m_cnt = m_cnt + 32'd1;
                m_pend.delete();
            end else begin
                m_halt  = 1'b1;
                m_fault = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk_next)
                chk("pc_next", pc_next, e.pc_next, e.cyc);
            chk("pc_en", 32'(pc_en), 32'(e.pc_en), e.cyc);
            chk("fetch_valid", 32'(fetch_valid), 32'(e.fetch_valid), e.cyc);
            if (e.chk_reg) begin
                chk("addr_fault", 32'(addr_fault), 32'(e.addr_fault), e.cyc);
                chk("fetch_cnt", fetch_cnt, e.fetch_cnt, e.cyc);
            end
        end
    end

    initial begin
        int          n;
        int          k;
        logic [31:0] rt;
        reset = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'd0; pc = 32'h3000;

        step(0, 0, 0, 0); step(0, 0, 0, 0);
        // Free run, then unstalled redirect at pc 0x3008
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 1, 32'h3100);
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        // Redirect held through a 3-cycle stall
        for (int i = 0; i < 3; i++) step(1, 1, 1, 32'h3200);
        step(1, 0, 1, 32'h3200);
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        // Misaligned target, then halted
        step(1, 0, 1, 32'h3002);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 32'h3100);
        // Reset out of HALT, out-of-range target
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h7000);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        // Reset during PEND discards the held target
        step(0, 0, 0, 0);
        step(1, 1, 1, 32'h3400); step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        // Stalled redirect to an illegal target faults on release
        step(1, 1, 1, 32'h2FFC); step(1, 0, 0, 0); step(1, 0, 0, 0);
        // Sequential free run off the end of memory
        step(0, 0, 0, 0);
        n = 0;
        while (!m_halt && n < 5000) begin
            step(1, 0, 0, 0);
            n++;
        end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 39);
            if (k == 0)      rt = 32'h3002 + 32'd4 * 32'($urandom_range(0, 100));
            else if (k == 1) rt = 32'h7000 + 32'd4 * 32'($urandom_range(0, 100));
            else if (k == 2) rt = 32'h2FFC;
            else             rt = 32'h3000 + 32'd4 * 32'($urandom_range(0, 4095));
            step($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 20, rt);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
